// File: rtl/keccak_obi_xfer_master.sv
// OBI initiator that copies a block of 32-bit words from src to dst, one
// read then one write per word, with a single outstanding transaction.
module keccak_obi_xfer_master #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned LEN_W  = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] src_addr_i,
   input  logic [ADDR_W-1:0] dst_addr_i,
   input  logic [LEN_W-1:0]  len_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic              obi_req_o,
   input  logic              obi_gnt_i,
   output logic [ADDR_W-1:0] obi_addr_o,
   output logic              obi_we_o,
   output logic [3:0]        obi_be_o,
   output logic [DATA_W-1:0] obi_wdata_o,
   input  logic              obi_rvalid_i,
   input  logic [DATA_W-1:0] obi_rdata_i
);

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      WR_REQ,
      WR_WAIT,
      DONE
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] src;
   logic [ADDR_W-1:0] dst;
   logic [LEN_W-1:0]  len;
   logic [LEN_W-1:0]  cnt;

   logic [LEN_W-1:0]  cnt_inc;
   logic [ADDR_W-1:0] rd_next_addr;
   logic [ADDR_W-1:0] wr_addr;
   logic              misaligned;

   // Word offsets wrap modulo 2^ADDR_W by construction of the adders.
   assign cnt_inc      = cnt + LEN_W'(1);
   assign rd_next_addr = src + (ADDR_W'(cnt_inc) << 2);
   assign wr_addr      = dst + (ADDR_W'(cnt) << 2);
   assign misaligned   = (src_addr_i[1:0] != 2'b00) || (dst_addr_i[1:0] != 2'b00);

   assign obi_be_o = 4'hF;

   // obi_wdata_o doubles as the read/write holding register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= IDLE;
         src         <= '0;
         dst         <= '0;
         len         <= '0;
         cnt         <= '0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         err_o       <= 1'b0;
         obi_req_o   <= 1'b0;
         obi_we_o    <= 1'b0;
         obi_addr_o  <= '0;
         obi_wdata_o <= '0;
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  if (misaligned) begin
                     state  <= DONE;
                     done_o <= 1'b1;
                     err_o  <= 1'b1;
                  end else if (len_i == '0) begin
                     state  <= DONE;
                     done_o <= 1'b1;
                     err_o  <= 1'b0;
                  end else begin
                     state      <= RD_REQ;
                     src        <= src_addr_i;
                     dst        <= dst_addr_i;
                     len        <= len_i;
                     cnt        <= '0;
                     err_o      <= 1'b0;
                     busy_o     <= 1'b1;
                     obi_req_o  <= 1'b1;
                     obi_we_o   <= 1'b0;
                     obi_addr_o <= src_addr_i;
                  end
               end
            end
            RD_REQ: begin
               if (obi_gnt_i) begin
                  state     <= RD_WAIT;
                  obi_req_o <= 1'b0;
               end
            end
            RD_WAIT: begin
               if (obi_rvalid_i) begin
                  state       <= WR_REQ;
                  obi_wdata_o <= obi_rdata_i;
                  obi_req_o   <= 1'b1;
                  obi_we_o    <= 1'b1;
                  obi_addr_o  <= wr_addr;
               end
            end
            WR_REQ: begin
               if (obi_gnt_i) begin
                  state     <= WR_WAIT;
                  obi_req_o <= 1'b0;
                  obi_we_o  <= 1'b0;
               end
            end
            WR_WAIT: begin
               if (obi_rvalid_i) begin
                  cnt <= cnt_inc;
                  if (cnt_inc == len) begin
                     state  <= DONE;
                     done_o <= 1'b1;
                     busy_o <= 1'b0;
                  end else begin
                     state      <= RD_REQ;
                     obi_req_o  <= 1'b1;
                     obi_addr_o <= rd_next_addr;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_keccak_obi_xfer_master.sv
// Self-checking bench: memory-model OBI slave with scoreboard queues of
// expected reads and writes, plus directed scenario tasks.
module tb_keccak_obi_xfer_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] src_addr = '0;
   logic [31:0] dst_addr = '0;
   logic [7:0]  len = '0;
   logic        busy, done, err;
   logic        obi_req;
   logic        obi_gnt = 1'b0;
   logic [31:0] obi_addr;
   logic        obi_we;
   logic [3:0]  obi_be;
   logic [31:0] obi_wdata;
   logic        obi_rvalid = 1'b0;
   logic [31:0] obi_rdata = '0;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [logic [31:0]];
   logic [31:0] exp_rd [$];
   logic [63:0] exp_wr [$];
   int          max_stall = 0;
   int          min_delay = 1;
   int          max_delay = 1;
   int          rd_grants = 0;
   int          rvalid_seen = 0;
   logic [31:0] last_wr_addr = '0;

   keccak_obi_xfer_master dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .start_i      (start),
      .src_addr_i   (src_addr),
      .dst_addr_i   (dst_addr),
      .len_i        (len),
      .busy_o       (busy),
      .done_o       (done),
      .err_o        (err),
      .obi_req_o    (obi_req),
      .obi_gnt_i    (obi_gnt),
      .obi_addr_o   (obi_addr),
      .obi_we_o     (obi_we),
      .obi_be_o     (obi_be),
      .obi_wdata_o  (obi_wdata),
      .obi_rvalid_i (obi_rvalid),
      .obi_rdata_i  (obi_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return 32'hBAD0_0000 ^ a;
   endfunction

   // OBI slave: grants after a random stall, responds after a random delay.
   initial begin
      int          resp_due;
      int          stall;
      bit          in_req;
      logic [31:0] resp_data, s_addr, s_wdata, e_addr;
      logic [63:0] e_wr;
      logic        s_we;
      resp_due = 0; stall = 0; in_req = 0;
      resp_data = '0; s_addr = '0; s_wdata = '0; s_we = 1'b0;
      forever begin
         @(negedge clk);
         obi_gnt    = 1'b0;
         obi_rvalid = 1'b0;
         if (resp_due > 0) begin
            resp_due--;
            if (resp_due == 0) begin
               obi_rvalid = 1'b1;
               obi_rdata  = resp_data;
               rvalid_seen++;
            end
         end
         if (rst || obi_req !== 1'b1) begin
            in_req = 0;
         end else begin
            if (!in_req) begin
               in_req  = 1;
               stall   = $urandom_range(0, max_stall);
               s_addr  = obi_addr;
               s_we    = obi_we;
               s_wdata = obi_wdata;
            end else begin
               checks++;
               if (obi_addr !== s_addr || obi_we !== s_we || (s_we && obi_wdata !== s_wdata)) begin
                  errors++;
                  $display("FAIL req_stable: addr=%h we=%b wdata=%h, required addr=%h we=%b wdata=%h",
                           obi_addr, obi_we, obi_wdata, s_addr, s_we, s_wdata);
               end
            end
            if (stall == 0) begin
               obi_gnt = 1'b1;
               in_req  = 0;
               checks++;
               if (obi_be !== 4'hF) begin
                  errors++;
                  $display("FAIL byte_enable: got %h, required f", obi_be);
               end
               checks++;
               if (!obi_we) begin
                  rd_grants++;
                  if (exp_rd.size() == 0) begin
                     errors++;
                     $display("FAIL unexpected_read: addr=%h, required no traffic", obi_addr);
                  end else begin
                     e_addr = exp_rd.pop_front();
                     if (obi_addr !== e_addr) begin
                        errors++;
                        $display("FAIL read_addr: got %h, required %h", obi_addr, e_addr);
                     end
                  end
                  resp_data = mem_rd(obi_addr);
               end else begin
                  if (exp_wr.size() == 0) begin
                     errors++;
                     $display("FAIL unexpected_write: addr=%h data=%h, required no traffic", obi_addr, obi_wdata);
                  end else begin
                     e_wr = exp_wr.pop_front();
                     if ({obi_addr, obi_wdata} !== e_wr) begin
                        errors++;
                        $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                                 obi_addr, obi_wdata, e_wr[63:32], e_wr[31:0]);
                     end
                  end
                  mem[obi_addr] = obi_wdata;
                  last_wr_addr  = obi_addr;
                  resp_data     = '0;
               end
               resp_due = $urandom_range(min_delay, max_delay);
            end else begin
               stall--;
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1);
   end

   task automatic push_expect(input logic [31:0] s, input logic [31:0] d, input int l);
      for (int i = 0; i < l; i++) begin
         exp_rd.push_back(s + 32'(4 * i));
         exp_wr.push_back({d + 32'(4 * i), mem_rd(s + 32'(4 * i))});
      end
   endtask

   // Leaves the caller at the first negedge after the start edge.
   task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input logic [7:0] l);
      @(negedge clk);
      src_addr = s; dst_addr = d; len = l; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int cyc0, input int max, output int cyc, output bit seen);
      cyc  = cyc0;
      seen = 0;
      while (cyc < max && !seen) begin
         @(negedge clk);
         cyc++;
         if (done) seen = 1;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, err, obi_req, obi_we} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags: busy/done/err/req/we=%b, required 00000", {busy, done, err, obi_req, obi_we});
      end
      checks++;
      if (obi_addr !== 32'h0 || obi_wdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_bus: addr=%h wdata=%h, required 0 0", obi_addr, obi_wdata);
      end
      checks++;
      if (obi_be !== 4'hF) begin
         errors++;
         $display("FAIL reset_be: got %h, required f", obi_be);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, obi_req} !== 3'b0) begin
         errors++;
         $display("FAIL idle_after_reset: busy/done/req=%b, required 000", {busy, done, obi_req});
      end
   endtask

   task automatic test_single_word;
      int cyc;
      bit seen;
      mem[32'h1000] = 32'hDEAD_BEEF;
      max_stall = 0; min_delay = 1; max_delay = 1;
      push_expect(32'h1000, 32'h2000, 1);
      pulse_start(32'h1000, 32'h2000, 8'd1);
      checks++;
      if (obi_req !== 1'b1 || busy !== 1'b1 || obi_we !== 1'b0 || obi_addr !== 32'h1000) begin
         errors++;
         $display("FAIL first_req: req=%b busy=%b we=%b addr=%h, required 1 1 0 00001000",
                  obi_req, busy, obi_we, obi_addr);
      end
      wait_done(1, 50, cyc, seen);
      checks++;
      if (!seen || cyc != 5) begin
         errors++;
         $display("FAIL single_done_latency: seen=%0d cycles=%0d, required 1 5", seen, cyc);
      end
      checks++;
      if (err !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL single_flags: err=%b busy=%b, required 0 0", err, busy);
      end
      checks++;
      if (mem_rd(32'h2000) !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL single_data: got %h, required deadbeef", mem_rd(32'h2000));
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || exp_rd.size() != 0 || exp_wr.size() != 0) begin
         errors++;
         $display("FAIL single_end: done=%b pending rd=%0d wr=%0d, required 0 0 0", done, exp_rd.size(), exp_wr.size());
      end
   endtask

   task automatic test_block50;
      int cyc;
      bit seen;
      int bad;
      int extra;
      for (int i = 0; i < 50; i++) mem[32'h4000 + 32'(4 * i)] = 32'(i);
      push_expect(32'h4000, 32'h8000, 50);
      pulse_start(32'h4000, 32'h8000, 8'd50);
      wait_done(1, 400, cyc, seen);
      checks++;
      if (!seen || cyc != 201) begin
         errors++;
         $display("FAIL block50_cycles: seen=%0d cycles=%0d, required 1 201", seen, cyc);
      end
      checks++;
      if (last_wr_addr !== 32'h80C4) begin
         errors++;
         $display("FAIL block50_last_addr: got %h, required 000080c4", last_wr_addr);
      end
      bad = 0;
      for (int i = 0; i < 50; i++) if (mem_rd(32'h8000 + 32'(4 * i)) !== 32'(i)) bad++;
      checks++;
      if (bad != 0 || exp_rd.size() != 0 || exp_wr.size() != 0) begin
         errors++;
         $display("FAIL block50_data: bad words=%0d pending rd=%0d wr=%0d, required 0 0 0", bad, exp_rd.size(), exp_wr.size());
      end
      extra = 0;
      repeat (6) begin
         @(negedge clk);
         if (done) extra++;
      end
      checks++;
      if (extra != 0) begin
         errors++;
         $display("FAIL block50_single_done: extra pulses=%0d, required 0", extra);
      end
   endtask

   task automatic test_stalls;
      int cyc;
      bit seen;
      int bad;
      logic [31:0] ref_data [20];
      for (int i = 0; i < 20; i++) begin
         ref_data[i] = $urandom;
         mem[32'hC000 + 32'(4 * i)] = ref_data[i];
      end
      max_stall = 5; min_delay = 1; max_delay = 4;
      push_expect(32'hC000, 32'hD000, 20);
      pulse_start(32'hC000, 32'hD000, 8'd20);
      wait_done(1, 2000, cyc, seen);
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL stalls_done: not seen within %0d cycles, required done", cyc);
      end
      bad = 0;
      for (int i = 0; i < 20; i++) if (mem_rd(32'hD000 + 32'(4 * i)) !== ref_data[i]) bad++;
      checks++;
      if (bad != 0 || exp_wr.size() != 0) begin
         errors++;
         $display("FAIL stalls_data: bad words=%0d pending wr=%0d, required 0 0", bad, exp_wr.size());
      end
      max_stall = 0; min_delay = 1; max_delay = 1;
      repeat (6) @(negedge clk);
   endtask

   task automatic test_error_and_len0;
      int cyc;
      bit seen;
      pulse_start(32'h1002, 32'h2000, 8'd4);
      checks++;
      if (done !== 1'b1 || err !== 1'b1 || obi_req !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL misaligned_src: done=%b err=%b req=%b busy=%b, required 1 1 0 0", done, err, obi_req, busy);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || err !== 1'b1) begin
         errors++;
         $display("FAIL err_sticky: done=%b err=%b, required 0 1", done, err);
      end
      pulse_start(32'h1000, 32'h2000, 8'd0);
      checks++;
      if (done !== 1'b1 || err !== 1'b0 || obi_req !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL len0: done=%b err=%b req=%b busy=%b, required 1 0 0 0", done, err, obi_req, busy);
      end
      pulse_start(32'h1000, 32'h2001, 8'd1);
      checks++;
      if (done !== 1'b1 || err !== 1'b1 || obi_req !== 1'b0) begin
         errors++;
         $display("FAIL misaligned_dst: done=%b err=%b req=%b, required 1 1 0", done, err, obi_req);
      end
      repeat (2) @(negedge clk);
      push_expect(32'h1000, 32'h3000, 1);
      pulse_start(32'h1000, 32'h3000, 8'd1);
      checks++;
      if (err !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL err_cleared: err=%b busy=%b, required 0 1", err, busy);
      end
      wait_done(1, 50, cyc, seen);
      checks++;
      if (!seen || cyc != 5 || err !== 1'b0 || mem_rd(32'h3000) !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL after_err_xfer: seen=%0d cycles=%0d err=%b data=%h, required 1 5 0 deadbeef",
                  seen, cyc, err, mem_rd(32'h3000));
      end
   endtask

   task automatic test_start_while_busy;
      int cyc;
      bit seen;
      int stray;
      for (int i = 0; i < 4; i++) mem[32'h5000 + 32'(4 * i)] = 32'hA500_0000 + 32'(i);
      push_expect(32'h5000, 32'h6000, 4);
      pulse_start(32'h5000, 32'h6000, 8'd4);
      repeat (3) @(negedge clk);
      src_addr = 32'h7000; dst_addr = 32'h7800; len = 8'd9; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(5, 200, cyc, seen);
      checks++;
      if (!seen || cyc != 17 || exp_rd.size() != 0 || exp_wr.size() != 0) begin
         errors++;
         $display("FAIL busy_start_ignored: seen=%0d cycles=%0d pending rd=%0d wr=%0d, required 1 17 0 0",
                  seen, cyc, exp_rd.size(), exp_wr.size());
      end
      src_addr = 32'h7000; dst_addr = 32'h7800; len = 8'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      stray = 0;
      repeat (4) begin
         if (busy !== 1'b0 || obi_req !== 1'b0 || done !== 1'b0) stray++;
         @(negedge clk);
      end
      checks++;
      if (stray != 0) begin
         errors++;
         $display("FAIL done_cycle_start_ignored: active cycles=%0d, required 0", stray);
      end
   endtask

   task automatic test_reset_mid;
      int cyc;
      bit seen;
      int base;
      int rv0;
      int stray;
      int bad;
      for (int i = 0; i < 6; i++) mem[32'h9000 + 32'(4 * i)] = 32'h9900_0000 + 32'(i);
      min_delay = 4; max_delay = 4;
      base = rd_grants;
      push_expect(32'h9000, 32'hA000, 6);
      pulse_start(32'h9000, 32'hA000, 8'd6);
      cyc = 0;
      while (rd_grants != base + 4 && cyc < 200) begin
         @(negedge clk);
         #1;
         cyc++;
      end
      checks++;
      if (rd_grants != base + 4) begin
         errors++;
         $display("FAIL reach_word3: read grants=%0d, required %0d", rd_grants - base, 4);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || obi_req !== 1'b0) begin
         errors++;
         $display("FAIL rd_wait_state: busy=%b req=%b, required 1 0", busy, obi_req);
      end
      rv0 = rvalid_seen;
      rst = 1'b1;
      exp_rd.delete();
      exp_wr.delete();
      @(negedge clk);
      checks++;
      if ({busy, done, err, obi_req, obi_we} !== 5'b0 || obi_addr !== 32'h0 || obi_wdata !== 32'h0) begin
         errors++;
         $display("FAIL mid_reset_outputs: flags=%b addr=%h wdata=%h, required 00000 0 0",
                  {busy, done, err, obi_req, obi_we}, obi_addr, obi_wdata);
      end
      rst = 1'b0;
      stray = 0;
      repeat (6) begin
         @(negedge clk);
         if (busy !== 1'b0 || obi_req !== 1'b0 || done !== 1'b0) stray++;
      end
      checks++;
      if (stray != 0 || rvalid_seen == rv0) begin
         errors++;
         $display("FAIL late_rvalid_ignored: active cycles=%0d late rvalids=%0d, required 0 >0", stray, rvalid_seen - rv0);
      end
      min_delay = 1; max_delay = 1;
      push_expect(32'h9000, 32'hA000, 6);
      pulse_start(32'h9000, 32'hA000, 8'd6);
      wait_done(1, 200, cyc, seen);
      bad = 0;
      for (int i = 0; i < 6; i++) if (mem_rd(32'hA000 + 32'(4 * i)) !== 32'h9900_0000 + 32'(i)) bad++;
      checks++;
      if (!seen || cyc != 25 || bad != 0 || exp_wr.size() != 0) begin
         errors++;
         $display("FAIL post_reset_xfer: seen=%0d cycles=%0d bad=%0d pending=%0d, required 1 25 0 0",
                  seen, cyc, bad, exp_wr.size());
      end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_block50();
      test_stalls();
      test_error_and_len0();
      test_start_while_busy();
      test_reset_mid();
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/keccak_obi_xfer_master.md
Name: keccak_obi_xfer_master

Overview:
- OBI initiator that moves a block of 32-bit words from system memory into the Keccak slave window, or from it back to memory.
- Used to load the 1600-bit state (50 words) and rate blocks, and to unload digests, without CPU load/store loops.
- Sits on an external-crossbar master port. Configured by a local control interface driven from the Keccak peripheral register block.
- Strictly one outstanding transaction; a single read/write holding register.

Parameters:
- ADDR_W, 32, OBI address width.
- DATA_W, 32, OBI data width; fixed at 32, byte enables are always 4'hF.
- LEN_W, 8, width of the word-count field; max transfer is 2^LEN_W-1 words.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- start_i  in  1  one-cycle start pulse; ignored unless idle
- src_addr_i  in  ADDR_W  source byte address; sampled on accepted start
- dst_addr_i  in  ADDR_W  destination byte address; sampled on accepted start
- len_i  in  LEN_W  number of words; sampled on accepted start
- busy_o  out  1  high from the cycle after an accepted start until done_o
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  sticky error flag; cleared by the next accepted start
- obi_req_o  out  1  OBI request
- obi_gnt_i  in  1  OBI grant
- obi_addr_o  out  ADDR_W  OBI address
- obi_we_o  out  1  OBI write enable
- obi_be_o  out  4  OBI byte enables, constant 4'hF
- obi_wdata_o  out  DATA_W  OBI write data
- obi_rvalid_i  in  1  OBI response valid
- obi_rdata_i  in  DATA_W  OBI read data

Behaviour:
- Reset: state IDLE. All outputs 0: busy_o, done_o, err_o, obi_req_o, obi_we_o, obi_addr_o, obi_wdata_o. obi_be_o stays 4'hF. Reset mid-transfer aborts immediately; a pending rvalid after reset is ignored.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE.
- Start acceptance (IDLE and start_i):
  - If src or dst address [1:0] != 0: go to DONE with err_o=1; no bus traffic.
  - Else if len_i == 0: go to DONE, err_o=0.
  - Else latch src, dst and len; clear the word counter; go to RD_REQ.
- RD_REQ: obi_req_o=1, we=0, addr=src+4*cnt. Request, addr and we are held stable until obi_gnt_i. On gnt go to RD_WAIT, with req deasserted the next cycle.
- RD_WAIT: on obi_rvalid_i, capture obi_rdata_i into the holding register and go to WR_REQ. rvalid arriving in the same cycle as gnt must not happen (one-outstanding OBI); the design need not handle it.
- WR_REQ: req=1, we=1, addr=dst+4*cnt, wdata=holding register. Held stable until gnt, then go to WR_WAIT.
- WR_WAIT: on rvalid (write response), increment cnt. If cnt+1 == len go to DONE, else go to RD_REQ.
- DONE: done_o=1 for exactly one cycle, busy_o=0, then IDLE. A start in the DONE cycle is ignored.
- Address arithmetic: modulo 2^ADDR_W; wrap past 0xFFFF_FFFC is allowed and not flagged.
- Counter: LEN_W bits; it never exceeds len.
- start_i while busy is ignored; latched config is unchanged.
- Throughput: a zero-wait-state slave (gnt in the same cycle as req, rvalid the next cycle) costs 4 cycles per word.
- Latency: accepted start to first obi_req_o is 1 cycle.

Test Plan:
- len=1, src=0x1000, dst=0x2000, mem[0x1000]=0xDEADBEEF, immediate gnt/rvalid -> one read at 0x1000 then one write at 0x2000 with wdata 0xDEADBEEF; done_o pulses 5 cycles after start; err_o=0.
- len=50, consecutive source words 0..49 -> 50 read/write pairs; last write addr = dst+0xC4; destination holds 0..49 in order; done_o pulses exactly once.
- Random gnt stalls of 0-5 cycles and rvalid delays of 1-4 cycles -> addr/we/wdata stay stable while req=1 and ungranted; data intact.
- src=0x1002 -> no obi_req_o; done_o pulses the cycle after start with err_o=1. A following valid start clears err_o.
- len=0 -> done_o the cycle after start, err_o=0, no bus traffic. start_i pulsed mid-transfer -> ignored; transfer count unchanged.
- rst_i asserted in RD_WAIT of word 3 -> next cycle all outputs 0 and state IDLE; late rvalid ignored; new transfer then completes correctly.
